// File: rtl/alu_seq_ctrl_if.sv
// Operand, result and arithmetic-unit bus for the multi-word ALU sequencer.
// master = sequencer side, slave = source/sink/arithmetic-unit side.
interface alu_seq_ctrl_if;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_sel;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic        alu_cmp;

  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_last;

  modport master (
    input  op_valid,
    input  op_a,
    input  op_b,
    output op_ready,
    output alu_a,
    output alu_b,
    output alu_sel,
    output alu_cin,
    input  alu_out,
    input  alu_cout,
    input  alu_cmp,
    output res_valid,
    output res_data,
    output res_last,
    input  res_ready
  );

  modport slave (
    output op_valid,
    output op_a,
    output op_b,
    input  op_ready,
    input  alu_a,
    input  alu_b,
    input  alu_sel,
    input  alu_cin,
    output alu_out,
    output alu_cout,
    output alu_cmp,
    input  res_valid,
    input  res_data,
    input  res_last,
    output res_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-word sequencer chaining carry across 16-bit ALU words.
// Optional operand-idle abort enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_seq_ctrl #(
  parameter int WCNT_W      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [3:0]        i_op_sel,
  input  logic [WCNT_W-1:0] i_word_cnt,
  input  logic              i_carry_init,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_final_carry,
  output logic              o_all_equal,
  output logic              o_timeout_err,
  alu_seq_ctrl_if.master    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic [3:0]        r_sel;
  logic              r_cin;
  logic              r_res_valid;
  logic [15:0]       r_res_data;
  logic              r_res_last;
  logic              r_final_carry;
  logic              r_all_eq;
  logic [WCNT_W-1:0] r_cnt;
  logic [WCNT_W-1:0] r_wlen;

  logic w_op_ready;
  logic w_accept;
  logic w_pop;
  logic w_last;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_err;
`endif

  // One-deep output buffer: accept whenever it is empty or draining now.
  assign w_op_ready = (r_state == S_RUN) &
                      (!r_res_valid | bus.res_ready);
  assign w_accept   = bus.op_valid & w_op_ready;
  assign w_pop      = r_res_valid & bus.res_ready;
  assign w_last     = (r_cnt == r_wlen - WCNT_W'(1));

  assign bus.alu_a     = bus.op_a;
  assign bus.alu_b     = bus.op_b;
  assign bus.alu_sel   = r_sel;
  assign bus.alu_cin   = r_cin;
  assign bus.op_ready  = w_op_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_last  = r_res_last;

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_final_carry = r_final_carry;
  assign o_all_equal   = r_all_eq;

`ifdef ALU_SEQ_TIMEOUT_EN
  assign o_timeout_err = r_tmo_err;
`else
  assign o_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sel         <= '0;
      r_cin         <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_last    <= 1'b0;
      r_final_carry <= 1'b0;
      r_all_eq      <= 1'b0;
      r_cnt         <= '0;
      r_wlen        <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      r_tmo_err     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_sel         <= i_op_sel;
            r_cin         <= i_carry_init;
            r_wlen        <= (i_word_cnt == '0) ?
                             WCNT_W'(1) : i_word_cnt;
            r_cnt         <= '0;
            r_all_eq      <= 1'b1;
            r_final_carry <= 1'b0;
            r_res_last    <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_RUN;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_tmo_err     <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (w_pop) begin
            r_res_valid <= 1'b0;
          end
          if (w_accept) begin
            r_res_valid   <= 1'b1;
            r_res_data    <= bus.alu_out;
            r_res_last    <= w_last;
            r_cin         <= bus.alu_cout;
            r_final_carry <= bus.alu_cout;
            r_all_eq      <= r_all_eq & bus.alu_cmp;
            r_cnt         <= r_cnt + WCNT_W'(1);
            if (w_last) begin
              r_state <= S_DRAIN;
            end
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          // Only a silent source counts; a stalled sink does not.
          if (w_accept) begin
            r_tmo_cnt <= '0;
          end else if (!bus.op_valid) begin
            if (r_tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
              r_tmo_err   <= 1'b1;
              r_res_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
          end
`endif
        end
        S_DRAIN: begin
          if (w_pop) begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural arithmetic unit.
// Define ALU_SEQ_TIMEOUT_EN to exercise the idle-operand abort path.
module tb_alu_seq_ctrl;
  localparam int WCNT_W = 4;
  localparam int TCYC   = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        op_sel = '0;
  logic [WCNT_W-1:0] word_cnt = '0;
  logic              carry_init = 1'b0;
  logic              busy;
  logic              done;
  logic              final_carry;
  logic              all_equal;
  logic              timeout_err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [16:0] sb[$];
  logic [16:0] mon_exp;
  logic [16:0] alu_sum;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl #(
    .WCNT_W      (WCNT_W),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_op_sel      (op_sel),
    .i_word_cnt    (word_cnt),
    .i_carry_init  (carry_init),
    .o_busy        (busy),
    .o_done        (done),
    .o_final_carry (final_carry),
    .o_all_equal   (all_equal),
    .o_timeout_err (timeout_err),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Behavioural arithmetic unit; sub is a - b + cin with cout = borrow.
  always_comb begin
    alu_sum      = '0;
    bus.alu_out  = bus.alu_a;
    bus.alu_cout = 1'b0;
    bus.alu_cmp  = (bus.alu_a == bus.alu_b);
    case (bus.alu_sel)
      4'b0000: bus.alu_out = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_out = bus.alu_a | bus.alu_b;
      4'b0010: bus.alu_out = bus.alu_a ^ bus.alu_b;
      4'b0011: bus.alu_out = ~bus.alu_a;
      4'b1001: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}
                + {16'd0, bus.alu_cin};
        bus.alu_out  = alu_sum[15:0];
        bus.alu_cout = alu_sum[16];
      end
      4'b0110: begin
        alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}
                + {16'd0, bus.alu_cin};
        bus.alu_out  = alu_sum[15:0];
        bus.alu_cout = alu_sum[16];
      end
      default: bus.alu_out = bus.alu_a;
    endcase
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL res_extra act=%h exp=none",
                   {bus.res_last, bus.res_data});
        end else begin
          mon_exp = sb.pop_front();
          chk("res_word", {15'd0, bus.res_last, bus.res_data},
              {15'd0, mon_exp});
        end
      end
    end
  end

  task automatic do_start(logic [3:0] s, logic [3:0] c, logic ci);
    start      = 1'b1;
    op_sel     = s;
    word_cnt   = c;
    carry_init = ci;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b, logic [16:0] e);
    int n;
    sb.push_back(e);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    n = 0;
    @(negedge clk);
    while (!bus.op_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL op_ready_wait act=0 exp=1");
    end
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic finish_op(string nm, logic fc, logic ae);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_fcarry"}, final_carry, fc);
    chk({nm, "_alleq"}, all_equal, ae);
    chk({nm, "_sb_empty"}, sb.size(), 0);
    exp_done++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_op_ready", bus.op_ready, 0);
    chk("rst_res", {bus.res_valid, bus.res_last, bus.res_data}, 0);
    chk("rst_alu", {bus.alu_sel, bus.alu_cin}, 0);
    chk("rst_flags", {final_carry, all_equal, timeout_err}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // add chain across three words
    do_start(4'b1001, 4'd3, 1'b0);
    chk("add_busy", busy, 1);
    chk("add_sel", bus.alu_sel, 4'b1001);
    send(16'hFFFF, 16'h0001, {1'b0, 16'h0000});
    send(16'hFFFF, 16'h0000, {1'b0, 16'h0000});
    send(16'h0001, 16'h0000, {1'b1, 16'h0002});
    finish_op("add", 1'b0, 1'b0);

    // equal subtract
    do_start(4'b0110, 4'd2, 1'b1);
    send(16'h1234, 16'h1234, {1'b0, 16'h0001});
    send(16'h5678, 16'h5678, {1'b1, 16'h0000});
    finish_op("sub", 1'b0, 1'b1);

    // backpressure mid-op
    do_start(4'b1001, 4'd4, 1'b0);
    send(16'h0001, 16'h0010, {1'b0, 16'h0011});
    send(16'h0002, 16'h0020, {1'b0, 16'h0022});
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_op_ready", bus.op_ready, 0);
      chk("bp_hold", {bus.res_valid, bus.res_data}, {1'b1, 16'h0022});
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    send(16'h0003, 16'h0030, {1'b0, 16'h0033});
    send(16'h0004, 16'h0040, {1'b1, 16'h0044});
    finish_op("bp", 1'b0, 1'b0);

    // word_cnt=0 is one word; start while busy is ignored
    do_start(4'b0010, 4'd0, 1'b0);
    do_start(4'b1111, 4'd5, 1'b1);
    chk("ign_sel", bus.alu_sel, 4'b0010);
    chk("ign_cin", bus.alu_cin, 0);
    send(16'h00FF, 16'h0F0F, {1'b1, 16'h0FF0});
    finish_op("one", 1'b0, 1'b0);

    // reset after the second of four accepts
    do_start(4'b1001, 4'd4, 1'b0);
    send(16'h0001, 16'h0000, {1'b0, 16'h0001});
    send(16'h0002, 16'h0000, {1'b0, 16'h0002});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_res_valid", bus.res_valid, 0);
    chk("mrst_sel", bus.alu_sel, 0);
    chk("mrst_op_ready", bus.op_ready, 0);
    chk("mrst_discard", sb.size(), 1);
    sb.delete();
    do_start(4'b1001, 4'd2, 1'b1);
    send(16'h8000, 16'h8000, {1'b0, 16'h0001});
    send(16'h7FFF, 16'h8000, {1'b1, 16'h0000});
    finish_op("post", 1'b1, 1'b0);

    // source goes silent in RUN
    do_start(4'b1001, 4'd2, 1'b0);
`ifdef ALU_SEQ_TIMEOUT_EN
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 50) begin
        n++;
        @(negedge clk);
      end
      chk("tmo_done", done, 1);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_res_valid", bus.res_valid, 0);
      exp_done++;
      @(posedge clk);
      #1;
    end
`else
    repeat (100) @(posedge clk);
    #1;
    chk("stall_busy", busy, 1);
    chk("stall_err", timeout_err, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
